// File: rtl/pixel_streamer_pkg.sv
// ---------------------------------------------------------------------------
// pixel_streamer_pkg
//   Shared definitions for the pixel_streamer slice: default pixel width and
//   image dimensions used by the convolution front end, the streamer FSM state
//   type, and a helper that sizes counters safely for degenerate dimensions.
// ---------------------------------------------------------------------------
package pixel_streamer_pkg;

   localparam int CNN_DATA_WIDTH = 16;
   localparam int CNN_IMG_WIDTH  = 28;
   localparam int CNN_IMG_HEIGHT = 28;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // Counter width for a range of n values; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pixel_streamer_if.sv
// ---------------------------------------------------------------------------
// pixel_streamer_if
//   Host write port, stream control and pixel stream of pixel_streamer.
//   master : host side (drives writes, start, stall; observes the stream)
//   slave  : pixel_streamer side
//   Signals:
//     wr_en/wr_addr/wr_data : RAM write port, row-major address
//     start                 : begin one frame (honoured only when idle)
//     stall                 : hold the stream, no read issued this cycle
//     out_valid/pixel_out   : valid-qualified signed pixel
//     sof/eol/eof           : frame/row markers, qualified by out_valid
//     busy/done             : frame in progress / one-cycle completion pulse
// ---------------------------------------------------------------------------
interface pixel_streamer_if
   import pixel_streamer_pkg::*;
#(
   parameter int DATA_WIDTH = CNN_DATA_WIDTH,
   parameter int ADDR_WIDTH = $clog2(CNN_IMG_WIDTH * CNN_IMG_HEIGHT)
);
   logic                         wr_en;
   logic [ADDR_WIDTH-1:0]        wr_addr;
   logic signed [DATA_WIDTH-1:0] wr_data;
   logic                         start;
   logic                         stall;
   logic                         out_valid;
   logic signed [DATA_WIDTH-1:0] pixel_out;
   logic                         sof;
   logic                         eol;
   logic                         eof;
   logic                         busy;
   logic                         done;

   modport master (
      output wr_en, wr_addr, wr_data, start, stall,
      input  out_valid, pixel_out, sof, eol, eof, busy, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, start, stall,
      output out_valid, pixel_out, sof, eol, eof, busy, done
   );
endinterface

// File: rtl/pixel_streamer_frame_ram.sv
// ---------------------------------------------------------------------------
// frame_ram
//   Single-clock frame store: one write port, one synchronous read-first
//   read port. The storage array has no reset; only the read data register
//   is cleared so the streamed pixel output starts at zero.
//   Ports:
//     i_clk, i_rst          : clock, async active-high reset (read reg only)
//     i_wr_en/addr/data     : write port; addresses >= DEPTH are dropped
//     i_rd_en, i_rd_addr    : read strobe and address
//     o_rd_data             : registered read data, holds when i_rd_en is low
// ---------------------------------------------------------------------------
module frame_ram #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 784,
   parameter int ADDR_WIDTH = 10
)(
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_wr_en,
   input  logic [ADDR_WIDTH-1:0]        i_wr_addr,
   input  logic signed [DATA_WIDTH-1:0] i_wr_data,
   input  logic                         i_rd_en,
   input  logic [ADDR_WIDTH-1:0]        i_rd_addr,
   output logic signed [DATA_WIDTH-1:0] o_rd_data
);

   logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic signed [DATA_WIDTH-1:0] r_rd_data;
   logic                         w_wr_ok;

   // Extra MSB so the bound also works when DEPTH == 2**ADDR_WIDTH.
   assign w_wr_ok = i_wr_en && ({1'b0, i_wr_addr} < (ADDR_WIDTH+1)'(DEPTH));

   always_ff @(posedge i_clk) begin
      if (w_wr_ok)
         r_mem[i_wr_addr] <= i_wr_data;
   end

   // Non-blocking update makes a same-cycle write/read return the old word.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_rd_data <= '0;
      else if (i_rd_en)
         r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pixel_streamer.sv
// ---------------------------------------------------------------------------
// pixel_streamer
//   Frame source for the convolution front end. Holds one image in frame_ram
//   (loaded through the interface write port) and on start streams it
//   row-major as a valid-qualified pixel stream with sof/eol/eof markers.
//   Ports:
//     i_clk : single clock, rising edge
//     i_rst : asynchronous active-high reset; clears state and outputs,
//             RAM contents are kept
//     px    : pixel_streamer_if slave modport (writes, start/stall, stream,
//             busy/done)
// ---------------------------------------------------------------------------
module pixel_streamer
   import pixel_streamer_pkg::*;
#(
   parameter int DATA_WIDTH = CNN_DATA_WIDTH,
   parameter int IMG_WIDTH  = CNN_IMG_WIDTH,
   parameter int IMG_HEIGHT = CNN_IMG_HEIGHT,
   parameter int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
)(
   input  logic       i_clk,
   input  logic       i_rst,
   pixel_streamer_if.slave px
);

   localparam int N     = IMG_WIDTH * IMG_HEIGHT;
   localparam int COL_W = cnt_width(IMG_WIDTH);
   localparam int ROW_W = cnt_width(IMG_HEIGHT + 1);

   state_t                       r_state;
   state_t                       w_next;
   logic                         w_issue;
   logic                         w_clear;
   logic                         w_last;
   logic                         w_col_end;
   logic [ADDR_WIDTH-1:0]        r_rd_addr;
   logic [COL_W-1:0]             r_col;
   logic [ROW_W-1:0]             r_row;
   logic                         r_valid;
   logic                         r_sof;
   logic                         r_eol;
   logic                         r_eof;
   logic                         r_done;
   logic signed [DATA_WIDTH-1:0] w_rd_data;

   assign w_last    = (r_rd_addr == ADDR_WIDTH'(N - 1));
   assign w_col_end = (r_col == COL_W'(IMG_WIDTH - 1));

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_issue = 1'b0;
      w_clear = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (px.start) begin
               w_next  = ST_STREAM;
               w_clear = 1'b1;
            end
         end
         ST_STREAM: begin
            if (!px.stall) begin
               w_issue = 1'b1;
               if (w_last)
                  w_next = ST_DONE;
            end
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // ---------------- read counters ----------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rd_addr <= '0;
         r_col     <= '0;
         r_row     <= '0;
      end else if (w_clear) begin
         r_rd_addr <= '0;
         r_col     <= '0;
         r_row     <= '0;
      end else if (w_issue) begin
         r_rd_addr <= r_rd_addr + 1'b1;
         if (w_col_end) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   // ---------------- output register stage ----------------
   // Flags are registered on the same edge as the RAM read data, so they
   // line up with out_valid. done follows the DONE state by one cycle, which
   // puts it after the last pixel with busy already low.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_sof   <= 1'b0;
         r_eol   <= 1'b0;
         r_eof   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_valid <= w_issue;
         r_sof   <= w_issue && (r_row == '0) && (r_col == '0);
         r_eol   <= w_issue && w_col_end;
         r_eof   <= w_issue && w_last;
         r_done  <= (r_state == ST_DONE);
      end
   end

   frame_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (N),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_frame_ram (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_wr_en   (px.wr_en),
      .i_wr_addr (px.wr_addr),
      .i_wr_data (px.wr_data),
      .i_rd_en   (w_issue),
      .i_rd_addr (r_rd_addr),
      .o_rd_data (w_rd_data)
   );

   assign px.out_valid = r_valid;
   assign px.pixel_out = w_rd_data;
   assign px.sof       = r_sof;
   assign px.eol       = r_eol;
   assign px.eof       = r_eof;
   assign px.busy      = (r_state != ST_IDLE);
   assign px.done      = r_done;

endmodule

// File: tb/tb_pixel_streamer.sv
// ---------------------------------------------------------------------------
// tb_pixel_streamer
//   Self-checking bench for pixel_streamer on a 5x5 image. Each scenario
//   fills per-cycle stimulus plans, a frame-level reference model derives the
//   expected per-cycle outputs, and the scenario compares them inline.
// ---------------------------------------------------------------------------
module tb_pixel_streamer;

   localparam int DW   = 16;
   localparam int W    = 5;
   localparam int H    = 5;
   localparam int N    = W * H;
   localparam int AW   = 5;
   localparam int MAXC = 128;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pixel_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) px();

   pixel_streamer #(
      .DATA_WIDTH (DW),
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .ADDR_WIDTH (AW)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .px    (px)
   );

   typedef struct packed {
      logic          v;
      logic          sof;
      logic          eol;
      logic          eof;
      logic          busy;
      logic          done;
      logic [DW-1:0] pix;
   } obs_t;

   obs_t          obs  [MAXC];
   obs_t          expv [MAXC];
   bit            st_pl [MAXC];
   bit            sl_pl [MAXC];
   bit            we_pl [MAXC];
   logic [AW-1:0] wa_pl [MAXC];
   logic [DW-1:0] wd_pl [MAXC];
   logic [DW-1:0] mem_model [N];
   logic [DW-1:0] last_pix;
   int            errors = 0;
   int            checks = 0;

   function automatic string fmt(input obs_t o);
      return $sformatf("v=%b sof=%b eol=%b eof=%b busy=%b done=%b pix=%0d",
                       o.v, o.sof, o.eol, o.eof, o.busy, o.done, $signed(o.pix));
   endfunction

   function automatic obs_t sample_now();
      return {px.out_valid, px.sof, px.eol, px.eof, px.busy, px.done, px.pixel_out};
   endfunction

   task automatic drive_idle();
      px.wr_en   = 1'b0;
      px.wr_addr = '0;
      px.wr_data = '0;
      px.start   = 1'b0;
      px.stall   = 1'b0;
   endtask

   task automatic clear_plan();
      for (int i = 0; i < MAXC; i++) begin
         st_pl[i] = 1'b0;
         sl_pl[i] = 1'b0;
         we_pl[i] = 1'b0;
         wa_pl[i] = '0;
         wd_pl[i] = '0;
      end
   endtask

   // Cycle i: outputs sampled 1 time unit after edge i, inputs of cycle i
   // driven at the same point and taken at edge i+1.
   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         obs[i]     = sample_now();
         px.start   = st_pl[i];
         px.stall   = sl_pl[i];
         px.wr_en   = we_pl[i];
         px.wr_addr = wa_pl[i];
         px.wr_data = wd_pl[i];
      end
      @(posedge clk); #1;
      drive_idle();
   endtask

   // Frame-level reference: a start seen while idle (and not before the
   // cycle after the previous done) opens a frame; from the next cycle on,
   // every non-stalled cycle emits the next pixel one cycle later. Writes
   // land after that cycle's read, so a same-cycle read sees the old word.
   task automatic build_expect(input int n);
      bit            active;
      int            k;
      int            start_c;
      int            ready;
      logic [DW-1:0] last;
      active  = 1'b0;
      k       = 0;
      start_c = 0;
      ready   = 0;
      for (int i = 0; i < n; i++) expv[i] = '0;
      for (int i = 0; i < n; i++) begin
         if (active && i > start_c) expv[i].busy = 1'b1;
         if (!active && i >= ready && st_pl[i]) begin
            active  = 1'b1;
            k       = 0;
            start_c = i;
         end else if (active && i > start_c && !sl_pl[i]) begin
            if (i + 1 < n) begin
               expv[i+1].v    = 1'b1;
               expv[i+1].pix  = mem_model[k];
               expv[i+1].sof  = (k == 0);
               expv[i+1].eol  = (k % W == W - 1);
               expv[i+1].eof  = (k == N - 1);
               expv[i+1].busy = 1'b1;
            end
            k++;
            if (k == N) begin
               active = 1'b0;
               if (i + 2 < n) expv[i+2].done = 1'b1;
               ready = i + 3;
            end
         end
         if (we_pl[i] && wa_pl[i] < N) mem_model[wa_pl[i]] = wd_pl[i];
      end
      last = last_pix;
      for (int i = 0; i < n; i++) begin
         if (expv[i].v) last = expv[i].pix;
         else           expv[i].pix = last;
      end
      last_pix = last;
   endtask

   task automatic load_image(input bit rnd);
      logic [DW-1:0] d;
      for (int a = 0; a < N; a++) begin
         @(posedge clk); #1;
         d = rnd ? DW'($urandom) : DW'(a);
         px.wr_en   = 1'b1;
         px.wr_addr = AW'(a);
         px.wr_data = d;
         mem_model[a] = d;
      end
      @(posedge clk); #1;
      drive_idle();
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      obs_t o;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      o = sample_now();
      checks++;
      if (o !== obs_t'(0)) begin
         errors++;
         $display("FAIL reset_outputs got %s exp all zero", fmt(o));
      end
      @(negedge clk);
      rst      = 1'b0;
      last_pix = '0;
      load_image(1'b0);
      clear_plan();
      build_expect(6);
      capture(6);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (obs[i] !== expv[i]) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got %s exp %s", i, fmt(obs[i]), fmt(expv[i]));
         end
      end
   endtask

   task automatic test_load_and_stream();
      int nv;
      int dc;
      clear_plan();
      st_pl[2] = 1'b1;
      build_expect(34);
      capture(34);
      nv = 0;
      dc = -1;
      for (int i = 0; i < 34; i++) begin
         checks++;
         if (obs[i] !== expv[i]) begin
            errors++;
            $display("FAIL stream cyc=%0d got %s exp %s", i, fmt(obs[i]), fmt(expv[i]));
         end
         if (obs[i].v) nv++;
         if (obs[i].done && dc < 0) dc = i;
      end
      checks++;
      if (nv !== N) begin
         errors++;
         $display("FAIL stream_count got %0d exp %0d", nv, N);
      end
      checks++;
      if (dc !== 2 + N + 2) begin
         errors++;
         $display("FAIL stream_done_cycle got %0d exp %0d", dc, 2 + N + 2);
      end
   endtask

   task automatic test_stall();
      int dc;
      clear_plan();
      st_pl[2] = 1'b1;
      // pixel 7 is on the output in cycle 2+2+7; stall the next three reads
      for (int i = 11; i < 14; i++) sl_pl[i] = 1'b1;
      build_expect(38);
      capture(38);
      dc = -1;
      for (int i = 0; i < 38; i++) begin
         checks++;
         if (obs[i] !== expv[i]) begin
            errors++;
            $display("FAIL stall cyc=%0d got %s exp %s", i, fmt(obs[i]), fmt(expv[i]));
         end
         if (obs[i].done && dc < 0) dc = i;
      end
      checks++;
      if (dc !== 2 + N + 2 + 3) begin
         errors++;
         $display("FAIL stall_done_cycle got %0d exp %0d", dc, 2 + N + 2 + 3);
      end
      checks++;
      if (obs[15].v !== 1'b1 || obs[15].pix !== DW'(8) || obs[14].v !== 1'b0) begin
         errors++;
         $display("FAIL stall_resume got %s exp pixel 8 after bubbles", fmt(obs[15]));
      end
   endtask

   task automatic test_ignored_start();
      int nv;
      clear_plan();
      st_pl[2]         = 1'b1;
      st_pl[7]         = 1'b1;   // while streaming
      st_pl[2 + N + 1] = 1'b1;   // in DONE, same cycle as eof
      st_pl[2 + N + 3] = 1'b1;   // cycle after the done pulse
      build_expect(62);
      capture(62);
      nv = 0;
      for (int i = 0; i < 62; i++) begin
         checks++;
         if (obs[i] !== expv[i]) begin
            errors++;
            $display("FAIL ignored_start cyc=%0d got %s exp %s", i, fmt(obs[i]), fmt(expv[i]));
         end
         if (obs[i].v) nv++;
      end
      checks++;
      if (nv !== 2 * N) begin
         errors++;
         $display("FAIL ignored_start_count got %0d exp %0d", nv, 2 * N);
      end
      checks++;
      if (obs[2 + N + 3 + 2].sof !== 1'b1) begin
         errors++;
         $display("FAIL second_frame_sof got %s exp sof=1", fmt(obs[2 + N + 3 + 2]));
      end
   endtask

   task automatic test_write_edges();
      clear_plan();
      we_pl[0] = 1'b1; wa_pl[0] = AW'(25); wd_pl[0] = DW'(99);
      st_pl[2] = 1'b1;
      // read of address 6 is issued in cycle 2+1+6
      we_pl[9] = 1'b1; wa_pl[9] = AW'(6);  wd_pl[9] = 16'hFFFD;
      st_pl[2 + N + 3] = 1'b1;
      build_expect(62);
      capture(62);
      for (int i = 0; i < 62; i++) begin
         checks++;
         if (obs[i] !== expv[i]) begin
            errors++;
            $display("FAIL write_edge cyc=%0d got %s exp %s", i, fmt(obs[i]), fmt(expv[i]));
         end
      end
      checks++;
      if (obs[10].pix !== DW'(6)) begin
         errors++;
         $display("FAIL same_cycle_old got %0d exp 6", $signed(obs[10].pix));
      end
      checks++;
      if (obs[2 + N + 3 + 2 + 6].pix !== 16'hFFFD) begin
         errors++;
         $display("FAIL next_frame_new got %0d exp -3", $signed(obs[2 + N + 3 + 2 + 6].pix));
      end
   endtask

   task automatic test_mid_reset();
      obs_t o;
      load_image(1'b0);
      clear_plan();
      st_pl[2] = 1'b1;
      build_expect(17);
      capture(17);
      for (int i = 0; i < 17; i++) begin
         checks++;
         if (obs[i] !== expv[i]) begin
            errors++;
            $display("FAIL pre_reset cyc=%0d got %s exp %s", i, fmt(obs[i]), fmt(expv[i]));
         end
      end
      #3;
      rst = 1'b1;
      #1;
      o = sample_now();
      checks++;
      if (o !== obs_t'(0)) begin
         errors++;
         $display("FAIL mid_reset_outputs got %s exp all zero", fmt(o));
      end
      @(negedge clk);
      rst      = 1'b0;
      last_pix = '0;
      clear_plan();
      build_expect(6);
      capture(6);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (obs[i] !== expv[i]) begin
            errors++;
            $display("FAIL post_reset_idle cyc=%0d got %s exp %s", i, fmt(obs[i]), fmt(expv[i]));
         end
      end
      clear_plan();
      st_pl[1] = 1'b1;
      build_expect(32);
      capture(32);
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (obs[i] !== expv[i]) begin
            errors++;
            $display("FAIL post_reset_frame cyc=%0d got %s exp %s", i, fmt(obs[i]), fmt(expv[i]));
         end
      end
   endtask

   task automatic test_random_stall();
      load_image(1'b1);
      clear_plan();
      st_pl[1] = 1'b1;
      for (int i = 0; i < 120; i++) sl_pl[i] = ($urandom_range(2, 0) == 0);
      build_expect(120);
      capture(120);
      for (int i = 0; i < 120; i++) begin
         checks++;
         if (obs[i] !== expv[i]) begin
            errors++;
            $display("FAIL random_stall cyc=%0d got %s exp %s", i, fmt(obs[i]), fmt(expv[i]));
         end
      end
   endtask

   initial begin
      drive_idle();
      last_pix = '0;
      test_reset();
      test_load_and_stream();
      test_stall();
      test_ignored_start();
      test_write_edges();
      test_mid_reset();
      test_random_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
